// File: rtl/water_mark_blend.sv
// Watermark blender: loads a short watermark burst into a local buffer, then
// blends it lane-wise onto an image stream through one output register stage.
module water_mark_blend #(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_LANE_WIDTH       = 8,
    parameter int C_WM_DEPTH         = 16,
    parameter int C_CNT_WIDTH        = 32
) (
    input  logic                          aclk,
    input  logic                          areset,

    input  logic                          ctrl_start,
    input  logic [1:0]                    ctrl_mode,
    output logic                          ctrl_busy,
    output logic                          ctrl_done,

    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_wm_tdata,
    input  logic                          s_axis_wm_tvalid,
    output logic                          s_axis_wm_tready,
    input  logic                          s_axis_wm_tlast,

    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_im_tdata,
    input  logic                          s_axis_im_tvalid,
    output logic                          s_axis_im_tready,
    input  logic                          s_axis_im_tlast,

    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_im_tdata,
    output logic                          m_axis_im_tvalid,
    input  logic                          m_axis_im_tready,
    output logic                          m_axis_im_tlast,

    output logic [C_CNT_WIDTH-1:0]        stat_beat_count
);

    localparam int LANES = C_AXIS_TDATA_WIDTH / C_LANE_WIDTH;
    localparam int AW    = (C_WM_DEPTH > 1) ? $clog2(C_WM_DEPTH) : 1;
    localparam int LENW  = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        BLEND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [1:0]                    mode_r;
    logic [LENW-1:0]               wm_len;
    logic [AW-1:0]                 rd_ptr;
    logic [LENW-1:0]               ptr_inc;
    logic                          last_seen;
    logic [C_AXIS_TDATA_WIDTH-1:0] wm_buf [C_WM_DEPTH];

    logic [C_AXIS_TDATA_WIDTH-1:0] out_data_p1;
    logic                          out_vld_p1;
    logic                          out_last_p1;
    logic [C_CNT_WIDTH-1:0]        beat_cnt;

    logic wm_hs;
    logic im_hs;
    logic out_hs;
    logic wm_wr_en;

    function automatic logic [C_LANE_WIDTH-1:0] sat_add(
        input logic [C_LANE_WIDTH-1:0] a,
        input logic [C_LANE_WIDTH-1:0] w
    );
        logic [C_LANE_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, w};
        return sum[C_LANE_WIDTH] ? {C_LANE_WIDTH{1'b1}} : sum[C_LANE_WIDTH-1:0];
    endfunction

    function automatic logic [C_AXIS_TDATA_WIDTH-1:0] blend_beat(
        input logic [C_AXIS_TDATA_WIDTH-1:0] a,
        input logic [C_AXIS_TDATA_WIDTH-1:0] w,
        input logic [1:0]                    m
    );
        logic [C_AXIS_TDATA_WIDTH-1:0] r;
        logic [C_LANE_WIDTH-1:0]       al;
        logic [C_LANE_WIDTH-1:0]       wl;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            al = a[i*C_LANE_WIDTH +: C_LANE_WIDTH];
            wl = w[i*C_LANE_WIDTH +: C_LANE_WIDTH];
            case (m)
                2'd0:    r[i*C_LANE_WIDTH +: C_LANE_WIDTH] = al;
                2'd1:    r[i*C_LANE_WIDTH +: C_LANE_WIDTH] = al ^ wl;
                2'd2:    r[i*C_LANE_WIDTH +: C_LANE_WIDTH] = sat_add(al, wl);
                default: r[i*C_LANE_WIDTH +: C_LANE_WIDTH] = (wl != '0) ? wl : al;
            endcase
        end
        return r;
    endfunction

    assign s_axis_wm_tready = (state == LOAD);
    // Once the image tlast is accepted, stop taking beats until it drains out.
    assign s_axis_im_tready = (state == BLEND) && !last_seen &&
                              (!out_vld_p1 || m_axis_im_tready);

    assign wm_hs    = s_axis_wm_tvalid && s_axis_wm_tready;
    assign im_hs    = s_axis_im_tvalid && s_axis_im_tready;
    assign out_hs   = out_vld_p1 && m_axis_im_tready;
    assign wm_wr_en = wm_hs && (wm_len < LENW'(C_WM_DEPTH));
    assign ptr_inc  = {1'b0, rd_ptr} + LENW'(1);

    assign ctrl_busy        = (state == LOAD) || (state == BLEND);
    assign ctrl_done        = (state == DONE);
    assign m_axis_im_tdata  = out_data_p1;
    assign m_axis_im_tvalid = out_vld_p1;
    assign m_axis_im_tlast  = out_last_p1;
    assign stat_beat_count  = beat_cnt;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ctrl_start) begin
                    state_nxt = (ctrl_mode == 2'd0) ? BLEND : LOAD;
                end
            end
            LOAD: begin
                if (wm_hs && s_axis_wm_tlast) begin
                    state_nxt = BLEND;
                end
            end
            BLEND: begin
                if (out_hs && out_last_p1) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Watermark buffer: write-only during LOAD, beats past the depth are dropped.
    always_ff @(posedge aclk) begin
        if (wm_wr_en) begin
            wm_buf[wm_len[AW-1:0]] <= s_axis_wm_tdata;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            mode_r      <= 2'd0;
            wm_len      <= '0;
            rd_ptr      <= '0;
            last_seen   <= 1'b0;
            beat_cnt    <= '0;
            out_data_p1 <= '0;
            out_vld_p1  <= 1'b0;
            out_last_p1 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl_start) begin
                        mode_r    <= ctrl_mode;
                        wm_len    <= '0;
                        rd_ptr    <= '0;
                        last_seen <= 1'b0;
                        beat_cnt  <= '0;
                    end
                end
                LOAD: begin
                    if (wm_wr_en) begin
                        wm_len <= wm_len + LENW'(1);
                    end
                end
                BLEND: begin
                    // Output register stage
                    if (im_hs) begin
                        out_data_p1 <= blend_beat(s_axis_im_tdata, wm_buf[rd_ptr], mode_r);
                        out_vld_p1  <= 1'b1;
                        out_last_p1 <= s_axis_im_tlast;
                        rd_ptr      <= (ptr_inc >= wm_len) ? '0 : ptr_inc[AW-1:0];
                        if (s_axis_im_tlast) begin
                            last_seen <= 1'b1;
                        end
                    end else if (out_hs) begin
                        out_vld_p1 <= 1'b0;
                    end
                    if (out_hs && (beat_cnt != {C_CNT_WIDTH{1'b1}})) begin
                        beat_cnt <= beat_cnt + C_CNT_WIDTH'(1);
                    end
                end
                default: begin
                    out_vld_p1 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_water_mark_blend.sv
// Directed bench for water_mark_blend: 32-bit stream, 8-bit lanes, 16-beat buffer.
module tb_water_mark_blend;

    localparam int DW    = 32;
    localparam int LW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 32;

    logic          aclk = 1'b0;
    logic          areset;
    logic          ctrl_start;
    logic [1:0]    ctrl_mode;
    logic          ctrl_busy;
    logic          ctrl_done;
    logic [DW-1:0] s_axis_wm_tdata;
    logic          s_axis_wm_tvalid;
    logic          s_axis_wm_tready;
    logic          s_axis_wm_tlast;
    logic [DW-1:0] s_axis_im_tdata;
    logic          s_axis_im_tvalid;
    logic          s_axis_im_tready;
    logic          s_axis_im_tlast;
    logic [DW-1:0] m_axis_im_tdata;
    logic          m_axis_im_tvalid;
    logic          m_axis_im_tready;
    logic          m_axis_im_tlast;
    logic [CW-1:0] stat_beat_count;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] wm   [32];
    logic [DW-1:0] img  [64];
    logic [DW-1:0] expv [64];

    water_mark_blend #(
        .C_AXIS_TDATA_WIDTH(DW),
        .C_LANE_WIDTH      (LW),
        .C_WM_DEPTH        (DEPTH),
        .C_CNT_WIDTH       (CW)
    ) dut (
        .aclk            (aclk),
        .areset          (areset),
        .ctrl_start      (ctrl_start),
        .ctrl_mode       (ctrl_mode),
        .ctrl_busy       (ctrl_busy),
        .ctrl_done       (ctrl_done),
        .s_axis_wm_tdata (s_axis_wm_tdata),
        .s_axis_wm_tvalid(s_axis_wm_tvalid),
        .s_axis_wm_tready(s_axis_wm_tready),
        .s_axis_wm_tlast (s_axis_wm_tlast),
        .s_axis_im_tdata (s_axis_im_tdata),
        .s_axis_im_tvalid(s_axis_im_tvalid),
        .s_axis_im_tready(s_axis_im_tready),
        .s_axis_im_tlast (s_axis_im_tlast),
        .m_axis_im_tdata (m_axis_im_tdata),
        .m_axis_im_tvalid(m_axis_im_tvalid),
        .m_axis_im_tready(m_axis_im_tready),
        .m_axis_im_tlast (m_axis_im_tlast),
        .stat_beat_count (stat_beat_count)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expd);
        n_vec++;
        assert (obs === expd) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expd);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_m_tvalid"}, m_axis_im_tvalid, 0);
        chk({tag, "_m_tdata"}, m_axis_im_tdata, 0);
        chk({tag, "_m_tlast"}, m_axis_im_tlast, 0);
        chk({tag, "_wm_tready"}, s_axis_wm_tready, 0);
        chk({tag, "_im_tready"}, s_axis_im_tready, 0);
        chk({tag, "_busy"}, ctrl_busy, 0);
        chk({tag, "_done"}, ctrl_done, 0);
        chk({tag, "_stat"}, stat_beat_count, 0);
    endtask

    task automatic do_start(input logic [1:0] m);
        @(negedge aclk);
        ctrl_start = 1'b1;
        ctrl_mode  = m;
        @(negedge aclk);
        ctrl_start = 1'b0;
        chk("busy_after_start", ctrl_busy, 1);
    endtask

    // Image traffic is presented throughout LOAD and must be held off.
    task automatic load_wm(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge aclk);
            s_axis_wm_tvalid = 1'b1;
            s_axis_wm_tdata  = wm[k];
            s_axis_wm_tlast  = (k == n - 1);
            s_axis_im_tvalid = 1'b1;
            s_axis_im_tdata  = 32'hDEAD_BEEF;
            s_axis_im_tlast  = 1'b0;
            #1;
            if (k == 0) begin
                chk("load_wm_tready", s_axis_wm_tready, 1);
                chk("load_im_tready", s_axis_im_tready, 0);
            end
            @(posedge aclk);
        end
        @(negedge aclk);
        s_axis_wm_tvalid = 1'b0;
        s_axis_wm_tlast  = 1'b0;
        s_axis_im_tvalid = 1'b0;
    endtask

    task automatic stream(input int n, input bit bp, input logic [CW-1:0] exp_cnt);
        int            in_idx  = 0;
        int            out_idx = 0;
        int            cyc     = 0;
        bit            stalled = 0;
        bit            ih;
        logic [DW-1:0] hd = '0;
        logic          hl = 1'b0;
        while (out_idx < n && cyc < 3000) begin
            @(negedge aclk);
            s_axis_im_tvalid = (in_idx < n);
            s_axis_im_tdata  = (in_idx < n) ? img[in_idx] : '0;
            s_axis_im_tlast  = (in_idx == n - 1);
            m_axis_im_tready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (stalled) begin
                chk("stall_data", m_axis_im_tdata, hd);
                chk("stall_vld", m_axis_im_tvalid, 1);
                chk("stall_last", m_axis_im_tlast, hl);
            end
            if (m_axis_im_tvalid && m_axis_im_tready) begin
                chk("out_data", m_axis_im_tdata, expv[out_idx]);
                chk("out_last", m_axis_im_tlast, (out_idx == n - 1));
                out_idx++;
            end
            ih      = s_axis_im_tvalid && s_axis_im_tready;
            stalled = m_axis_im_tvalid && !m_axis_im_tready;
            hd      = m_axis_im_tdata;
            hl      = m_axis_im_tlast;
            @(posedge aclk);
            if (ih) in_idx++;
            cyc++;
        end
        chk("stream_beats_out", out_idx, n);
        chk("stream_beats_in", in_idx, n);
        @(negedge aclk);
        s_axis_im_tvalid = 1'b0;
        s_axis_im_tlast  = 1'b0;
        m_axis_im_tready = 1'b1;
        chk("done_pulse", ctrl_done, 1);
        chk("busy_in_done", ctrl_busy, 0);
        chk("stat_count", stat_beat_count, exp_cnt);
        @(negedge aclk);
        chk("done_single", ctrl_done, 0);
        chk("extra_out", m_axis_im_tvalid, 0);
    endtask

    initial begin
        logic [7:0] b;
        areset           = 1'b1;
        ctrl_start       = 1'b0;
        ctrl_mode        = 2'd0;
        s_axis_wm_tdata  = '0;
        s_axis_wm_tvalid = 1'b0;
        s_axis_wm_tlast  = 1'b0;
        s_axis_im_tdata  = '0;
        s_axis_im_tvalid = 1'b0;
        s_axis_im_tlast  = 1'b0;
        m_axis_im_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk_reset_outputs("reset");
        @(negedge aclk);
        areset = 1'b0;

        // XOR: 4 wm beats of 0xFF over 10 image beats of 0x0F
        for (int k = 0; k < 4; k++) wm[k] = 32'hFFFF_FFFF;
        for (int j = 0; j < 10; j++) begin
            img[j]  = 32'h0F0F_0F0F;
            expv[j] = 32'hF0F0_F0F0;
        end
        do_start(2'd1);
        load_wm(4);
        stream(10, 1'b0, 10);

        // Saturating add
        wm[0]   = 32'h8080_8080;
        img[0]  = 32'h9010_9010;
        img[1]  = 32'h1090_1090;
        expv[0] = 32'hFF90_FF90;
        expv[1] = 32'h90FF_90FF;
        do_start(2'd2);
        load_wm(1);
        stream(2, 1'b0, 2);

        // Replace-if-nonzero, 3-beat wrap, zero lanes keep the image
        wm[0] = 32'h1122_3344;
        wm[1] = 32'h0000_0000;
        wm[2] = 32'h00AA_00BB;
        for (int j = 0; j < 7; j++) begin
            b      = 8'(8'h10 + j);
            img[j] = {4{b}};
        end
        expv[0] = 32'h1122_3344;
        expv[1] = 32'h1111_1111;
        expv[2] = 32'h12AA_12BB;
        expv[3] = 32'h1122_3344;
        expv[4] = 32'h1414_1414;
        expv[5] = 32'h15AA_15BB;
        expv[6] = 32'h1122_3344;
        do_start(2'd3);
        load_wm(3);
        stream(7, 1'b0, 7);

        // Overlong watermark: 20 beats accepted, only the first 16 kept
        for (int k = 0; k < 20; k++) begin
            b     = 8'(k + 1);
            wm[k] = {4{b}};
        end
        for (int j = 0; j < 17; j++) begin
            b       = 8'((j % 16) + 1);
            img[j]  = '0;
            expv[j] = {4{b}};
        end
        do_start(2'd1);
        load_wm(20);
        stream(17, 1'b0, 17);

        // Pass-through under random backpressure
        for (int j = 0; j < 64; j++) begin
            img[j]  = $urandom;
            expv[j] = img[j];
        end
        do_start(2'd0);
        stream(64, 1'b1, 64);

        // Reset in the middle of BLEND with a stalled output beat
        wm[0] = 32'h0F0F_0F0F;
        wm[1] = 32'hF0F0_F0F0;
        do_start(2'd1);
        load_wm(2);
        @(negedge aclk);
        s_axis_im_tvalid = 1'b1;
        s_axis_im_tdata  = 32'h1234_5678;
        s_axis_im_tlast  = 1'b0;
        m_axis_im_tready = 1'b0;
        @(negedge aclk);
        s_axis_im_tvalid = 1'b0;
        chk("abort_vld", m_axis_im_tvalid, 1);
        chk("abort_data", m_axis_im_tdata, 32'h1D3B_5977);
        areset = 1'b1;
        #1;
        chk_reset_outputs("midjob_reset");
        repeat (3) begin
            @(negedge aclk);
            chk("reset_no_done", ctrl_done, 0);
        end
        areset           = 1'b0;
        m_axis_im_tready = 1'b1;

        wm[0]   = 32'hFF00_FF00;
        wm[1]   = 32'h0F0F_0F0F;
        img[0]  = 32'h0000_0000;
        img[1]  = 32'h1111_1111;
        img[2]  = 32'h2222_2222;
        expv[0] = 32'hFF00_FF00;
        expv[1] = 32'h1E1E_1E1E;
        expv[2] = 32'hDD22_DD22;
        do_start(2'd1);
        load_wm(2);
        stream(3, 1'b0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
